// File: rtl/slot_machine_n.sv
// ---------------------------------------------------------------------------
// slot_machine_n
//   N-reel slot machine with credit accounting for the FPGA board top level.
//   Each reel is a symbol counter that cycles 0..LIMIT while spinning. A rising
//   edge on play starts a spin if there is credit. Each rising edge on stop
//   freezes the next reel, starting with reel 0. When the last reel stops, the
//   block spends one cycle checking for a jackpot. A jackpot adds JACKPOT
//   credits, and the credit counter saturates at its maximum value.
//
// Ports
//   i_clk_2       system clock; all state updates on the rising edge
//   i_reset_n     asynchronous active-low reset
//   i_play        level input; a rising edge starts a spin
//   i_stop        level input; a rising edge stops the next reel
//   o_reels       reel i at [i*SYMBOL_BITS +: SYMBOL_BITS] (drives the LCD)
//   o_stopped     bit i set when reel i is frozen
//   o_credits     current credit balance
//   o_busy        high while spinning or evaluating
//   o_win         one-cycle pulse on a jackpot
//   o_game_over   high while idle with no credits left
// ---------------------------------------------------------------------------
module slot_machine_n #(
  parameter int unsigned NREELS        = 3,
  parameter int unsigned SYMBOL_BITS   = 4,
  parameter int unsigned LIMIT         = 6,
  parameter int unsigned CREDIT_BITS   = 8,
  parameter int unsigned START_CREDITS = 10,
  parameter int unsigned JACKPOT       = 5
) (
  input  logic                            i_clk_2,
  input  logic                            i_reset_n,
  input  logic                            i_play,
  input  logic                            i_stop,
  output logic [NREELS*SYMBOL_BITS-1:0]   o_reels,
  output logic [NREELS-1:0]               o_stopped,
  output logic [CREDIT_BITS-1:0]          o_credits,
  output logic                            o_busy,
  output logic                            o_win,
  output logic                            o_game_over
);

  localparam int unsigned IDX_BITS = $clog2(NREELS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SPIN = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;

  logic [SYMBOL_BITS-1:0]  r_reels [NREELS];
  logic [NREELS-1:0]       r_stopped;
  logic [IDX_BITS-1:0]     r_idx;
  logic [CREDIT_BITS-1:0]  r_credits;
  logic                    r_win;
  logic                    r_playPrev;
  logic                    r_stopPrev;

  logic                    w_playRise;
  logic                    w_stopRise;
  logic                    w_creditsZero;
  logic                    w_lastStop;
  logic                    w_allEqual;
  logic                    w_startSpin;
  logic                    w_stopReel;
  logic                    w_jackpot;
  logic [CREDIT_BITS:0]    w_creditSum;
  logic [CREDIT_BITS-1:0]  w_creditSat;

  assign w_playRise    = i_play & ~r_playPrev;
  assign w_stopRise    = i_stop & ~r_stopPrev;
  assign w_creditsZero = (r_credits == '0);
  assign w_lastStop    = (r_idx == IDX_BITS'(NREELS - 1));

  // The sum uses one extra bit so an overflow can be seen and clamped to
  // the largest value the counter can hold.
  assign w_creditSum = {1'b0, r_credits} + (CREDIT_BITS + 1)'(JACKPOT);
  assign w_creditSat = w_creditSum[CREDIT_BITS] ? '1 : w_creditSum[CREDIT_BITS-1:0];

  always_comb begin
    w_allEqual = 1'b1;
    for (int i = 1; i < int'(NREELS); i++) begin
      if (r_reels[i] != r_reels[0]) w_allEqual = 1'b0;
    end
  end

  always_ff @(posedge i_clk_2 or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_nextState;
  end

  // In SPIN, play is ignored, so a stop press on the same edge as a play
  // press is the only one that has an effect.
  always_comb begin
    w_nextState = r_state;
    w_startSpin = 1'b0;
    w_stopReel  = 1'b0;
    w_jackpot   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_playRise && !w_creditsZero) begin
          w_startSpin = 1'b1;
          w_nextState = S_SPIN;
        end
      end
      S_SPIN: begin
        if (w_stopRise) begin
          w_stopReel = 1'b1;
          if (w_lastStop) w_nextState = S_EVAL;
        end
      end
      S_EVAL: begin
        w_jackpot   = w_allEqual;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Reels advance only in SPIN. A reel that is being stopped on this edge
  // keeps its current value. Reels are never reloaded, so the next spin
  // starts from the symbols the last spin left on screen.
  always_ff @(posedge i_clk_2 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(NREELS); i++) r_reels[i] <= '0;
      r_stopped  <= '0;
      r_idx      <= '0;
      r_credits  <= CREDIT_BITS'(START_CREDITS);
      r_win      <= 1'b0;
      r_playPrev <= 1'b0;
      r_stopPrev <= 1'b0;
    end else begin
      r_playPrev <= i_play;
      r_stopPrev <= i_stop;
      r_win      <= w_jackpot;
      if (w_startSpin) begin
        r_credits <= r_credits - 1'b1;
        r_stopped <= '0;
        r_idx     <= '0;
      end
      if (w_jackpot) r_credits <= w_creditSat;
      if (r_state == S_SPIN) begin
        for (int i = 0; i < int'(NREELS); i++) begin
          if (w_stopReel && (i == int'(r_idx))) begin
            r_stopped[i] <= 1'b1;
          end else if (!r_stopped[i]) begin
            r_reels[i] <= (r_reels[i] == SYMBOL_BITS'(LIMIT)) ? '0 : r_reels[i] + 1'b1;
          end
        end
      end
      if (w_stopReel) r_idx <= r_idx + 1'b1;
    end
  end

  for (genvar g = 0; g < int'(NREELS); g++) begin : g_reelOut
    assign o_reels[g*SYMBOL_BITS +: SYMBOL_BITS] = r_reels[g];
  end

  assign o_stopped   = r_stopped;
  assign o_credits   = r_credits;
  assign o_win       = r_win;
  assign o_busy      = (r_state == S_SPIN) || (r_state == S_EVAL);
  assign o_game_over = (r_state == S_IDLE) && w_creditsZero;

endmodule

// File: tb/tb_slot_machine_n.sv
// ---------------------------------------------------------------------------
// tb_slot_machine_n
//   Testbench for slot_machine_n. It builds three instances that share the
//   same inputs:
//     0 - default parameters
//     1 - START_CREDITS=1, so the machine runs out of credit
//     2 - CREDIT_BITS=4, START_CREDITS=14, so the credit counter saturates
//   A reference model tracks every instance and is compared each cycle.
//   It holds each reel as an integer and the number of reels stopped so far.
//   The bench also runs a hand-computed vector table on instance 0, a few
//   directed corner sequences, and a randomized run.
// ---------------------------------------------------------------------------
module tb_slot_machine_n;

  localparam int NINST = 3;
  localparam int NR    = 3;
  localparam int LIM   = 6;
  localparam int JACK  = 5;
  localparam int PH_IDLE     = 0;
  localparam int PH_SPINNING = 1;
  localparam int PH_SETTLE   = 2;

  logic clk;
  logic rst_n;
  logic play;
  logic stop;

  logic [11:0] reelsO   [NINST];
  logic [2:0]  stoppedO [NINST];
  logic [7:0]  credO    [NINST];
  logic        busyO    [NINST];
  logic        winO     [NINST];
  logic        goO      [NINST];
  logic [3:0]  satCredits;

  int totalChecks = 0;
  int failCount   = 0;

  // Reference model state, one entry per instance.
  int mReel  [NINST][NR];
  int mCred  [NINST];
  int mPhase [NINST];
  int mCnt   [NINST];
  bit mWin   [NINST];
  bit mPrevP;
  bit mPrevS;
  int mStart [NINST] = '{10, 1, 14};
  int mMax   [NINST] = '{255, 255, 15};

  typedef struct {
    logic        play;
    logic        stop;
    logic [11:0] expReels;
    logic [2:0]  expStopped;
    logic [7:0]  expCredits;
    logic        expBusy;
    logic        expWin;
  } vec_t;

  vec_t vecs[$];

  slot_machine_n dut (
    .i_clk_2(clk), .i_reset_n(rst_n), .i_play(play), .i_stop(stop),
    .o_reels(reelsO[0]), .o_stopped(stoppedO[0]), .o_credits(credO[0]),
    .o_busy(busyO[0]), .o_win(winO[0]), .o_game_over(goO[0])
  );

  slot_machine_n #(.START_CREDITS(1)) dutLow (
    .i_clk_2(clk), .i_reset_n(rst_n), .i_play(play), .i_stop(stop),
    .o_reels(reelsO[1]), .o_stopped(stoppedO[1]), .o_credits(credO[1]),
    .o_busy(busyO[1]), .o_win(winO[1]), .o_game_over(goO[1])
  );

  slot_machine_n #(.CREDIT_BITS(4), .START_CREDITS(14)) dutSat (
    .i_clk_2(clk), .i_reset_n(rst_n), .i_play(play), .i_stop(stop),
    .o_reels(reelsO[2]), .o_stopped(stoppedO[2]), .o_credits(satCredits),
    .o_busy(busyO[2]), .o_win(winO[2]), .o_game_over(goO[2])
  );

  assign credO[2] = {4'b0000, satCredits};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < NINST; k++) begin
      for (int r = 0; r < NR; r++) mReel[k][r] = 0;
      mCred[k]  = mStart[k];
      mPhase[k] = PH_IDLE;
      mCnt[k]   = 0;
      mWin[k]   = 0;
    end
    mPrevP = 0;
    mPrevS = 0;
  endfunction

  // One clock edge of the game. Reels at or beyond the stop count are
  // still spinning, and the reel being stopped now keeps its value.
  function automatic void modelStep(input logic p, input logic s);
    bit pr;
    bit sr;
    bit same;
    pr = p && !mPrevP;
    sr = s && !mPrevS;
    for (int k = 0; k < NINST; k++) begin
      mWin[k] = 0;
      if (mPhase[k] == PH_IDLE) begin
        if (pr && mCred[k] > 0) begin
          mCred[k]--;
          mCnt[k]   = 0;
          mPhase[k] = PH_SPINNING;
        end
      end else if (mPhase[k] == PH_SPINNING) begin
        for (int r = 0; r < NR; r++) begin
          if (r > mCnt[k] || (r == mCnt[k] && !sr)) mReel[k][r] = (mReel[k][r] + 1) % (LIM + 1);
        end
        if (sr) begin
          mCnt[k]++;
          if (mCnt[k] == NR) mPhase[k] = PH_SETTLE;
        end
      end else begin
        same = 1;
        for (int r = 1; r < NR; r++) if (mReel[k][r] != mReel[k][0]) same = 0;
        if (same) begin
          mCred[k] = (mCred[k] + JACK > mMax[k]) ? mMax[k] : mCred[k] + JACK;
          mWin[k]  = 1;
        end
        mPhase[k] = PH_IDLE;
      end
    end
    mPrevP = p;
    mPrevS = s;
  endfunction

  task automatic checkAll();
    int expR;
    for (int k = 0; k < NINST; k++) begin
      expR = 0;
      for (int r = 0; r < NR; r++) expR |= mReel[k][r] << (4 * r);
      checkOutput($sformatf("inst%0d reels", k), int'(reelsO[k]), expR);
      checkOutput($sformatf("inst%0d stopped", k), int'(stoppedO[k]), (1 << mCnt[k]) - 1);
      checkOutput($sformatf("inst%0d credits", k), int'(credO[k]), mCred[k]);
      checkOutput($sformatf("inst%0d busy", k), int'(busyO[k]), int'(mPhase[k] != PH_IDLE));
      checkOutput($sformatf("inst%0d win", k), int'(winO[k]), int'(mWin[k]));
      checkOutput($sformatf("inst%0d game_over", k), int'(goO[k]),
                  int'(mPhase[k] == PH_IDLE && mCred[k] == 0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep(play, stop);
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic p, input logic s);
    play = p;
    stop = s;
    tick();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #2;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void addVec(input logic p, input logic s, input int r0, input int r1,
                                 input int r2, input int st, input int c, input logic b,
                                 input logic w);
    vec_t v;
    v.play       = p;
    v.stop       = s;
    v.expReels   = 12'(r0 | (r1 << 4) | (r2 << 8));
    v.expStopped = 3'(st);
    v.expCredits = 8'(c);
    v.expBusy    = b;
    v.expWin     = w;
    vecs.push_back(v);
  endfunction

  initial begin
    play  = 1'b0;
    stop  = 1'b0;
    rst_n = 1'b1;
    #3;
    applyReset();

    // Instance 0 from reset: a full spin with wrap 6->0, a jackpot with stops
    // 7 cycles apart, then a losing spin with stops 2 cycles apart.
    addVec(0, 0, 0, 0, 0, 0, 10, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 9, 1, 0);
    for (int k = 1; k <= 7; k++) addVec(k == 1, 0, k % 7, k % 7, k % 7, 0, 9, 1, 0);
    addVec(0, 1, 0, 1, 1, 1, 9, 1, 0);
    addVec(0, 1, 0, 2, 2, 1, 9, 1, 0);
    for (int j = 3; j <= 7; j++) addVec(0, 0, 0, j % 7, j % 7, 1, 9, 1, 0);
    addVec(0, 1, 0, 0, 1, 3, 9, 1, 0);
    for (int j = 2; j <= 7; j++) addVec(0, 0, 0, 0, j % 7, 3, 9, 1, 0);
    addVec(0, 1, 0, 0, 0, 7, 9, 1, 0);
    addVec(0, 0, 0, 0, 0, 7, 14, 0, 1);
    addVec(0, 0, 0, 0, 0, 7, 14, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 13, 1, 0);
    addVec(0, 1, 0, 1, 1, 1, 13, 1, 0);
    addVec(0, 0, 0, 2, 2, 1, 13, 1, 0);
    addVec(0, 1, 0, 2, 3, 3, 13, 1, 0);
    addVec(0, 0, 0, 2, 4, 3, 13, 1, 0);
    addVec(0, 1, 0, 2, 4, 7, 13, 1, 0);
    addVec(0, 0, 0, 2, 4, 7, 13, 0, 0);

    $display("[TB] Vector table: %0d rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].play, vecs[i].stop);
      checkOutput($sformatf("vec%0d reels", i), int'(reelsO[0]), int'(vecs[i].expReels));
      checkOutput($sformatf("vec%0d stopped", i), int'(stoppedO[0]), int'(vecs[i].expStopped));
      checkOutput($sformatf("vec%0d credits", i), int'(credO[0]), int'(vecs[i].expCredits));
      checkOutput($sformatf("vec%0d busy", i), int'(busyO[0]), int'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d win", i), int'(winO[0]), int'(vecs[i].expWin));
      // Instance 2 hits the jackpot on the same cycle: 13 + 5 saturates to 15.
      if (i == 24) checkOutput("sat credits", int'(credO[2]), 15);
    end

    // A losing spin drains the single credit of instance 1. After that,
    // a play press is ignored there.
    $display("[TB] Out-of-credit sequence");
    applyReset();
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("low credits", int'(credO[1]), 0);
    checkOutput("low game_over", int'(goO[1]), 1);
    applyStimulus(1, 0);
    checkOutput("low busy after play", int'(busyO[1]), 0);
    checkOutput("low game_over held", int'(goO[1]), 1);

    // Instance 0 is now spinning. Holding stop stops only one reel.
    $display("[TB] Held stop and simultaneous press");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1);
    checkOutput("held stop stopped", int'(stoppedO[0]), 1);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    checkOutput("play+stop stopped", int'(stoppedO[0]), 3);
    checkOutput("play+stop busy", int'(busyO[0]), 1);
    applyStimulus(0, 0);

    // Reset in the middle of a spin returns to idle with a full balance.
    $display("[TB] Reset mid-spin");
    applyReset();
    checkOutput("rst reels", int'(reelsO[0]), 0);
    checkOutput("rst stopped", int'(stoppedO[0]), 0);
    checkOutput("rst credits", int'(credO[0]), 10);
    checkOutput("rst busy", int'(busyO[0]), 0);
    checkOutput("rst low credits", int'(credO[1]), 1);

    $display("[TB] Randomized run");
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) play = !play;
      if ($urandom_range(0, 2) == 0) stop = !stop;
      if ($urandom_range(0, 399) == 0) applyReset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", totalChecks, failCount);
    $finish;
  end

endmodule
